// File: rtl/sram_mem_responder.sv
// MEM-stage data-memory responder: serves one 32-bit load/store as two halfword
// accesses on a 16-bit asynchronous SRAM, holding ready low while busy.
module sram_mem_responder #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in
);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [SRAM_AW-2:0] word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;

    logic        req, last;
    logic [31:0] offset;
    logic        unused_offset_bits;

    assign req    = mem_r_en | mem_w_en;
    assign last   = (cnt_q == LAST);
    assign offset = address - 32'(BASE_ADDR);
    // Bits above the SRAM halfword range wrap away silently.
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
    assign rdata  = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    word_d  = offset[SRAM_AW:2];
                    wdata_d = wdata;
                    cnt_d   = '0;
                    state_d = mem_w_en ? WR_LO : RD_LO;
                end
            end
            RD_LO, RD_HI, WR_LO, WR_HI: begin
                cnt_d = last ? 4'd0 : cnt_q + 4'd1;
                if (last) begin
                    case (state_q)
                        RD_LO: begin
                            rdata_d[15:0] = sram_dq_in;
                            state_d       = RD_HI;
                        end
                        RD_HI: begin
                            rdata_d[31:16] = sram_dq_in;
                            state_d        = DONE;
                        end
                        WR_LO:   state_d = WR_HI;
                        default: state_d = DONE;
                    endcase
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state, so reset parks the bus at once.
    always_comb begin
        ready       = 1'b0;
        sram_addr   = '0;
        sram_we_n   = 1'b1;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        case (state_q)
            IDLE:  ready = ~req;
            RD_LO: sram_addr = {word_q, 1'b0};
            RD_HI: sram_addr = {word_q, 1'b1};
            WR_LO: begin
                sram_addr   = {word_q, 1'b0};
                sram_dq_oe  = 1'b1;
                sram_dq_out = wdata_q[15:0];
                sram_we_n   = (WAIT_CYCLES > 1) && last;
            end
            WR_HI: begin
                sram_addr   = {word_q, 1'b1};
                sram_dq_oe  = 1'b1;
                sram_dq_out = wdata_q[31:16];
                sram_we_n   = (WAIT_CYCLES > 1) && last;
            end
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule

// File: doc/sram_mem_responder.md
Name: sram_mem_responder

Overview:
- Responder end of the MEM-stage data-memory interface.
- Accepts one 32-bit read or write request at a time from the pipeline MEM stage.
- Serves the request over an external 16-bit asynchronous SRAM as two halfword accesses.
- Holds `ready` low while busy so the top level can freeze the pipeline. Replaces the single-cycle data memory behind MEM_Stage.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: cycles per halfword SRAM access; legal range 1..15.
- SRAM_AW, 18: SRAM halfword address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_r_en  input  1  read request from MEM stage; held stable while ready=0.
- mem_w_en  input  1  write request from MEM stage; held stable while ready=0.
- address  input  32  byte address (ALU result).
- wdata  input  32  store data (Val_Rm).
- rdata  output  32  load data; valid from the ready=1 completion cycle until the next read completes.
- ready  output  1  0 = freeze pipeline; 1 = request done, or no request pending.
- sram_addr  output  SRAM_AW  SRAM halfword address.
- sram_we_n  output  1  SRAM write enable, active-low.
- sram_dq_out  output  16  write data toward SRAM.
- sram_dq_oe  output  1  1 = drive sram_dq_out onto the SRAM bus (top level builds the tristate).
- sram_dq_in  input  16  read data from the SRAM bus.

Behaviour:
- **Reset (rst=0, asynchronous):**
  - state=IDLE, counter=0, latched addr/data=0, rdata=0.
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - ready follows the IDLE rule below.
  - Reset mid-access aborts immediately, with no further SRAM write strobes.
- **Request:** req = mem_r_en | mem_w_en. If both are set, the request is a write.
- **Address translation:**
  - word = (address - BASE_ADDR) >> 2, computed modulo 2^32.
  - lo halfword = {word, 0}; hi halfword = {word, 1}; both truncated to SRAM_AW bits, so out-of-range addresses wrap silently.
- **States:** IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- **IDLE:**
  - ready = ~req, combinational, so it drops in the same cycle the request appears.
  - On req: latch word, wdata and the write flag; counter=0; go to WR_LO if write, else RD_LO.
  - No req: stay in IDLE.
- **RD_LO / RD_HI:**
  - sram_addr = lo / hi halfword; sram_we_n=1; sram_dq_oe=0.
  - counter increments each cycle.
  - On the cycle where counter==WAIT_CYCLES-1: capture sram_dq_in into rdata[15:0] (RD_LO) or rdata[31:16] (RD_HI), reset counter, then advance RD_LO->RD_HI->DONE.
- **WR_LO / WR_HI:**
  - sram_addr = lo / hi halfword; sram_dq_oe=1.
  - sram_dq_out = wdata_q[15:0] / wdata_q[31:16].
  - sram_we_n=0 on every cycle of the phase except the last (counter==WAIT_CYCLES-1), where sram_we_n=1 and data stays driven (hold time). With WAIT_CYCLES=1, we_n is low for the whole single cycle.
  - Advance WR_LO->WR_HI->DONE.
- **DONE:**
  - ready=1 for exactly one cycle; the pipeline advances at this edge.
  - Go to IDLE unconditionally. A request present in the following cycle is treated as a new request.
  - sram_we_n=1; sram_dq_oe=0.
- **Outputs outside the active states:** ready=0 in all states except IDLE (with no req) and DONE.
- **Latency:** ready is low for 2*WAIT_CYCLES+1 cycles per access, counting the request cycle, then high for 1 cycle.
- **rdata on writes:** rdata is unchanged by writes. A partial read aborted by reset leaves rdata=0.
- **Input stability:** changes to address/wdata after latching have no effect on the access in progress.

Test Plan:
1. Reset, then idle: rst=0 for 2 cycles, then rst=1 with no request -> ready=1, sram_we_n=1, sram_dq_oe=0, rdata=0.
2. Write, WAIT_CYCLES=2: mem_w_en=1, address=1024+8, wdata=0xDEADBEEF ->
   - ready=0 for 5 cycles;
   - WR_LO drives addr=4, dq_out=0xBEEF, we_n low 1 cycle;
   - WR_HI drives addr=5, dq_out=0xDEAD;
   - then ready=1 for 1 cycle;
   - the SRAM model holds mem[4]=0xBEEF, mem[5]=0xDEAD.
3. Readback: after test 2, mem_r_en=1, address=1032 -> ready=0 for 5 cycles, rdata=0xDEADBEEF in the ready=1 cycle; sram_we_n stays 1 throughout.
4. Simultaneous read and write: mem_r_en=mem_w_en=1, address=1024, wdata=0x12345678 -> write performed (mem[0]=0x5678, mem[1]=0x1234); rdata unchanged.
5. Back-to-back requests: request held through DONE and re-asserted with a new address=1036 -> second access starts the cycle after DONE, takes 5 more stalled cycles, and the first access is not repeated.
6. Reset mid-write: rst=0 during WR_HI -> sram_we_n=1 and sram_dq_oe=0 immediately (asynchronously); state=IDLE; mem[hi] not written; ready=1 once rst=1 with no request.
